// File: rtl/cordic_pkg.sv
// CORDIC iteration sequencer shared types.
// State encoding, adder select codes and adder op codes.
package cordic_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    DIR,
    ISSUE_X,
    WAIT_X,
    ISSUE_Y,
    WAIT_Y,
    ISSUE_Z,
    WAIT_Z,
    UPDATE,
    DONE
  } state_t;

  localparam logic [1:0] SEL_X = 2'b00;
  localparam logic [1:0] SEL_Y = 2'b01;
  localparam logic [1:0] SEL_Z = 2'b10;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cordic_dir_unit.sv
// Rotation direction from mode and datapath signs.
// In: mode, sign_y, sign_z. Out: dir (1 means d = +1).
module cordic_dir_unit
  import cordic_pkg::*;
(
  input  logic mode,
  input  logic sign_y,
  input  logic sign_z,
  output logic dir
);

  logic s;

  always_comb begin
    s = sign_z;
    unique case (1'b1)
      mode:    s = sign_y;
      default: s = sign_z;
    endcase
    dir = ~(mode ^ s);
  end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// CORDIC micro-rotation sequencer driving one shared adder.
// In: clk, rst, beg/ack, mode, signs, add_ready. Out: datapath strobes, status.
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 16,
  parameter int W_ITER     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beg_fsm_cordic,
  input  logic              ack_cordic,
  input  logic              mode,
  input  logic              sign_y,
  input  logic              sign_z,
  input  logic              add_ready,
  output logic              load_init,
  output logic [W_ITER-1:0] iter_cnt,
  output logic              add_start,
  output logic [1:0]        add_sel,
  output logic              add_op,
  output logic              cap_en,
  output logic              commit,
  output logic              busy,
  output logic              ready_cordic
);

  localparam logic [W_ITER-1:0] LAST = W_ITER'(ITERATIONS - 1);

  state_t state;
  logic   mode_q;
  logic   dir_q;
  logic   dir_c;

  cordic_dir_unit u_dir (
    .mode   (mode_q),
    .sign_y (sign_y),
    .sign_z (sign_z),
    .dir    (dir_c)
  );

  // Capture strobe tracks the adder reply directly so the
  // temp register loads in the same cycle the result is valid.
  always_comb begin
    cap_en = 1'b0;
    if (state == WAIT_X || state == WAIT_Y || state == WAIT_Z)
      cap_en = add_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mode_q       <= 1'b0;
      dir_q        <= 1'b0;
      iter_cnt     <= '0;
      load_init    <= 1'b0;
      add_start    <= 1'b0;
      add_sel      <= SEL_X;
      add_op       <= OP_ADD;
      commit       <= 1'b0;
      busy         <= 1'b0;
      ready_cordic <= 1'b0;
    end else begin
      load_init <= 1'b0;
      add_start <= 1'b0;
      commit    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (beg_fsm_cordic) begin
            state     <= LOAD;
            load_init <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          state    <= DIR;
          iter_cnt <= '0;
          mode_q   <= mode;
        end
        DIR: begin
          // add_op uses the fresh direction, not last pass's.
          state     <= ISSUE_X;
          dir_q     <= dir_c;
          add_start <= 1'b1;
          add_sel   <= SEL_X;
          add_op    <= dir_c;
        end
        ISSUE_X: state <= WAIT_X;
        WAIT_X: begin
          if (add_ready) begin
            state     <= ISSUE_Y;
            add_start <= 1'b1;
            add_sel   <= SEL_Y;
            add_op    <= ~dir_q;
          end
        end
        ISSUE_Y: state <= WAIT_Y;
        WAIT_Y: begin
          if (add_ready) begin
            state     <= ISSUE_Z;
            add_start <= 1'b1;
            add_sel   <= SEL_Z;
            add_op    <= dir_q;
          end
        end
        ISSUE_Z: state <= WAIT_Z;
        WAIT_Z: begin
          if (add_ready) begin
            state   <= UPDATE;
            commit  <= 1'b1;
            add_sel <= SEL_X;
            add_op  <= OP_ADD;
          end
        end
        UPDATE: begin
          if (iter_cnt == LAST) begin
            state        <= DONE;
            busy         <= 1'b0;
            ready_cordic <= 1'b1;
          end else begin
            state    <= DIR;
            iter_cnt <= iter_cnt + 1'b1;
          end
        end
        DONE: begin
          if (ack_cordic) begin
            state        <= IDLE;
            ready_cordic <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
- Iteration sequencer for the iterative CORDIC coprocessor.
- Accepts a start request and runs ITERATIONS micro-rotations.
- Each iteration computes the rotation direction from the datapath sign bits, then issues three ordered operations (X, Y, Z) to one shared floating-point add/subtract unit through a start/ready handshake.
- Commits the results, then holds the done flag until the host acknowledges it.

Parameters:
- ITERATIONS, 16, number of micro-rotations per run (≥1).
- W_ITER, 5, iteration counter width; must be ≥ clog2(ITERATIONS).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- beg_fsm_cordic  in  1  start request; sampled only in IDLE.
- ack_cordic  in  1  host acknowledge of result; sampled only in DONE.
- mode  in  1  0 = rotation (z drives direction), 1 = vectoring (y drives direction); latched in LOAD.
- sign_y  in  1  sign bit of current Y register.
- sign_z  in  1  sign bit of current Z register.
- add_ready  in  1  shared adder result valid; honoured only in WAIT_* states.
- load_init  out  1  one-cycle pulse: datapath loads initial x, y, z.
- iter_cnt  out  W_ITER  current iteration index; drives shift amount and atan LUT address.
- add_start  out  1  one-cycle pulse launching the shared adder.
- add_sel  out  2  operand and capture select: 00 X, 01 Y, 10 Z; 11 is never driven.
- add_op  out  1  0 = add, 1 = subtract; valid while add_sel is valid.
- cap_en  out  1  pulse: capture adder result into the add_sel temp register (same cycle add_ready is seen).
- commit  out  1  one-cycle pulse: temp X/Y/Z copied into working registers.
- busy  out  1  high in every state except IDLE and DONE.
- ready_cordic  out  1  result valid; high in DONE only.

Behaviour:
- Reset: state = IDLE; every output 0; iter_cnt = 0; latched mode and dir = 0. Applies from any state, including mid-iteration; an outstanding adder operation is abandoned.
- States and transitions:
  - IDLE: on beg_fsm_cordic → LOAD.
  - LOAD: pulse load_init; iter_cnt ← 0; latch mode; → DIR.
  - DIR: s = mode ? sign_y : sign_z; dir ← ~(mode ^ s), where dir = 1 means d = +1; → ISSUE_X.
  - ISSUE_X: pulse add_start; add_sel = 00; add_op = dir; → WAIT_X.
  - WAIT_X: hold add_sel/add_op; on add_ready pulse cap_en → ISSUE_Y.
  - ISSUE_Y / WAIT_Y: add_sel = 01; add_op = ~dir; on add_ready pulse cap_en → ISSUE_Z.
  - ISSUE_Z / WAIT_Z: add_sel = 10; add_op = dir; on add_ready pulse cap_en → UPDATE.
  - UPDATE: pulse commit; if iter_cnt == ITERATIONS-1 → DONE (iter_cnt held); else iter_cnt +1 → DIR.
  - DONE: ready_cordic = 1; on ack_cordic → IDLE. ready_cordic drops the cycle after ack.
- add_op/add_sel are registered with the state and stay stable from ISSUE through the WAIT exit cycle.
- Latency with add_ready on the first WAIT cycle: 8 cycles per iteration.
  - beg_fsm_cordic sampled at edge k → LOAD in cycle k+1.
  - ready_cordic high from cycle k+2+8·ITERATIONS.
  - Each extra adder wait cycle adds 1 cycle.
- Boundaries:
  - beg_fsm_cordic while busy or in DONE: ignored.
  - add_ready outside WAIT_*: ignored, no cap_en.
  - add_ready high in the ISSUE cycle itself: ignored, so the adder must respond ≥1 cycle after add_start.
  - ack_cordic and beg_fsm_cordic high together in DONE: return to IDLE; the start is not accepted that cycle.
  - ITERATIONS = 1: exactly one pass, then DONE with iter_cnt = 0.
  - mode or sign changes mid-run: mode is ignored after LOAD; signs are sampled only in DIR.

Decomposition:
- Shared package cordic_pkg holds:
  - state enum (IDLE, LOAD, DIR, ISSUE_X, WAIT_X, ISSUE_Y, WAIT_Y, ISSUE_Z, WAIT_Z, UPDATE, DONE);
  - add_sel encodings SEL_X/SEL_Y/SEL_Z;
  - OP_ADD = 0, OP_SUB = 1.
- One sub-module: cordic_dir_unit, combinational. Inputs mode, sign_y, sign_z; output dir.

Test Plan:
1. ITERATIONS=4; rotation mode; sign_z=0 throughout; adder replies 1 cycle after start → ready_cordic at k+34; iter_cnt 0,1,2,3; X/Y/Z ops 1/0/1 each iteration; 4 commit pulses.
2. Vectoring mode; sign_y=0 → dir=0, ops X/Y/Z = 0/1/0. Then sign_y=1 before the second DIR → ops flip to 1/0/1 in iteration 1.
3. Adder delay 3 cycles on Y only, ITERATIONS=2 → completion 4 cycles later than case 1 at equal N; no cap_en before add_ready.
4. rst asserted in WAIT_Y of iteration 2 → next cycle IDLE, all outputs 0. A fresh start then completes normally with iter_cnt from 0.
5. beg_fsm_cordic pulsed during busy and held in DONE → no restart. Assert ack → IDLE; the following start is accepted.
6. Spurious add_ready in DIR, UPDATE and DONE → no cap_en, no state change, identical commit count.
